// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared mode encodings and reset-duty helper for the breathing controller
package pwm_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF    = 2'b00;
  localparam mode_t MODE_ON     = 2'b01;
  localparam mode_t MODE_BREATH = 2'b10;
  localparam mode_t MODE_BLINK  = 2'b11;

  // Phase-staggered start duty for channel idx: evenly spread over the PWM range,
  // clipped so it always fits in cnt_w bits.
  function automatic int reset_duty(input int idx, input int n_ch, input int cnt_w);
    int full;
    int v;
    full = 1 << cnt_w;
    v    = (idx * full) / n_ch;
    if (v > full - 1) begin
      v = full - 1;
    end
    return v;
  endfunction

endpackage

// File: rtl/pwm_breath_ch.sv
// rtl/pwm_breath_ch.sv - one LED duty engine: mode decode, triangle/blink duty, PWM compare
module pwm_breath_ch
  import pwm_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int STEP       = 1,
  parameter int ACTIVE_LOW = 0,
  parameter int RESET_DUTY = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             wrap_i,
  input  logic             upd_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             led_o
);

  localparam logic [CNT_W-1:0] MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STEP_V   = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] RST_DUTY = CNT_W'(RESET_DUTY);
  localparam logic             AL_BIT   = (ACTIVE_LOW != 0);

  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] duty_act_q, duty_act_d;
  logic             dir_q, dir_d;
  logic             on_q, on_d;
  logic             led_q, led_d;

  // Frame-boundary update: mode is only looked at on a wrap, so the compare value
  // and the forced-on flag never change in the middle of a frame.
  always_comb begin
    duty_d     = duty_q;
    dir_d      = dir_q;
    duty_act_d = duty_act_q;
    on_d       = on_q;
    if (wrap_i) begin
      case (mode_i)
        MODE_OFF: begin
          on_d       = 1'b0;
          duty_act_d = '0;
        end
        MODE_ON: begin
          // duty_act cannot express 2**CNT_W, so full-on is a separate flag.
          on_d = 1'b1;
        end
        MODE_BREATH: begin
          on_d = 1'b0;
          if (upd_i) begin
            if (dir_q) begin
              // Compare before adding so the CNT_W-bit sum can never wrap.
              if (duty_q >= MAX - STEP_V) begin
                duty_d = MAX;
                dir_d  = 1'b0;
              end else begin
                duty_d = duty_q + STEP_V;
              end
            end else begin
              if (duty_q <= STEP_V) begin
                duty_d = '0;
                dir_d  = 1'b1;
              end else begin
                duty_d = duty_q - STEP_V;
              end
            end
          end
          duty_act_d = duty_d;
        end
        default: begin
          on_d = 1'b0;
          if (upd_i) begin
            duty_d = (duty_q != '0) ? '0 : MAX;
          end
          duty_act_d = duty_d;
        end
      endcase
    end
  end

  // PWM compare against the frame-latched duty; disabled channels go inactive.
  always_comb begin
    led_d = AL_BIT;
    if (en_i) begin
      led_d = (on_q || (cnt_i < duty_act_q)) ^ AL_BIT;
    end
  end

  // Channel state registers; reset restores this channel's phase offset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      duty_q     <= RST_DUTY;
      duty_act_q <= RST_DUTY;
      dir_q      <= 1'b1;
      on_q       <= 1'b0;
      led_q      <= AL_BIT;
    end else begin
      duty_q     <= duty_d;
      duty_act_q <= duty_act_d;
      dir_q      <= dir_d;
      on_q       <= on_d;
      led_q      <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/pwm_breath_multi.sv
// rtl/pwm_breath_multi.sv - multi-channel LED breathing controller with shared PWM timebase
module pwm_breath_multi
  import pwm_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 8,
  parameter int PRESCALE   = 105,
  parameter int UPD_FRAMES = 4,
  parameter int STEP       = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2*N_CH-1:0] mode,
  output logic              frame_start,
  output logic [N_CH-1:0]   led_out
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FW = (UPD_FRAMES > 1) ? $clog2(UPD_FRAMES) : 1;
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FW-1:0]    frm_q, frm_d;
  logic             fs_q, fs_d;
  logic             tick;
  logic             wrap;
  logic             upd;

  assign tick = en && (presc_q == PW'(PRESCALE - 1));
  assign wrap = tick && (cnt_q == MAX);
  assign upd  = wrap && (frm_q == FW'(UPD_FRAMES - 1));

  // Shared timebase next state: everything holds while en is low.
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    frm_d   = frm_q;
    fs_d    = wrap;
    if (en) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
    if (tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (wrap) begin
      frm_d = upd ? '0 : frm_q + FW'(1);
    end
  end

  // Shared timebase registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      frm_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      frm_q   <= frm_d;
      fs_q    <= fs_d;
    end
  end

  assign frame_start = fs_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_breath_ch #(
      .CNT_W      (CNT_W),
      .STEP       (STEP),
      .ACTIVE_LOW (ACTIVE_LOW),
      .RESET_DUTY (reset_duty(i, N_CH, CNT_W))
    ) u_ch (
      .clk_i  (clk),
      .rst_i  (rst),
      .en_i   (en),
      .wrap_i (wrap),
      .upd_i  (upd),
      .mode_i (mode[2*i +: 2]),
      .cnt_i  (cnt_q),
      .led_o  (led_out[i])
    );
  end

endmodule
